nb_delay_pipe: RTL and testbench

Clocked, synthesizable producer stage that models `reg_lvalue <= #N expr` in cycle form. Each value presented on the input is delivered to a held value register exactly DELAY clocks later, with any number of deliveries in flight. A built-in sampling checker compares the held value against expected values and keeps sticky pass/fail status. It feeds the self-checking monitor stage, replacing the unclocked intra-assignment delay with a cycle-exact, resettable equivalent.

---
 rtl/nb_delay_pipe.sv | 58 +++++
 tb/tb_nb_delay_pipe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nb_delay_pipe.sv
// nb_delay_pipe: cycle-exact, resettable form of `value <= #DELAY in_data`,
// with a sampling checker that keeps sticky pass/fail status.
module nb_delay_pipe #(
   parameter int WIDTH = 4,
   parameter int DELAY = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] value,
   output logic             out_valid,
   output logic             delivered,
   output logic [6:0]       inflight,
   input  logic             chk_en,
   input  logic             chk_empty,
   input  logic [WIDTH-1:0] chk_data,
   output logic [7:0]       pass_cnt,
   output logic             fail
);
   logic             r_vld [DELAY];
   logic [WIDTH-1:0] r_dat [DELAY];
   logic             w_dlv;
   logic             w_ok;

   assign w_dlv = r_vld[DELAY-1];
   // the check sees the registered value/delivered, i.e. the pre-delivery state
   assign w_ok  = chk_empty ? !delivered : (delivered && value == chk_data);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < DELAY; k++) begin
            r_vld[k] <= 1'b0;
            r_dat[k] <= '0;
         end
         value     <= '0;
         out_valid <= 1'b0;
         delivered <= 1'b0;
         inflight  <= '0;
         pass_cnt  <= '0;
         fail      <= 1'b0;
      end else begin
         r_vld[0] <= in_valid;
         r_dat[0] <= in_data;
         for (int k = 1; k < DELAY; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_dat[k] <= r_dat[k-1];
         end
         out_valid <= w_dlv;
         if (w_dlv) begin
            value     <= r_dat[DELAY-1];
            delivered <= 1'b1;
         end
         inflight <= inflight + 7'(in_valid) - 7'(w_dlv);
         if (chk_en && w_ok && pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
         if (chk_en && !w_ok) fail <= 1'b1;
      end
endmodule

// File: tb/tb_nb_delay_pipe.sv
// tb_nb_delay_pipe: directed steps with a delivery scoreboard and checker model.
module tb_nb_delay_pipe;
   localparam int DELAY = 10;

   typedef struct {
      logic [3:0] d;
      int         due;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = '0;
   logic       chk_en = 1'b0;
   logic       chk_empty = 1'b0;
   logic [3:0] chk_data = '0;
   logic [3:0] value;
   logic       out_valid;
   logic       delivered;
   logic [6:0] inflight;
   logic [7:0] pass_cnt;
   logic       fail;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         mon_on = 1'b0;
   ent_t       q[$];
   logic [3:0] m_value = '0;
   bit         m_deliv = 1'b0;
   int         m_pass = 0;
   bit         m_fail = 1'b0;

   nb_delay_pipe #(.WIDTH(4), .DELAY(DELAY)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .value(value), .out_valid(out_valid), .delivered(delivered),
      .inflight(inflight), .chk_en(chk_en), .chk_empty(chk_empty),
      .chk_data(chk_data), .pass_cnt(pass_cnt), .fail(fail)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: pop and compare when a delivery is due
   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("out_valid_due", 32'(out_valid), 32'd1);
            chk("value_deliv", 32'(value), 32'(q[0].d));
            m_value = q[0].d;
            m_deliv = 1'b1;
            void'(q.pop_front());
         end else
            chk("out_valid_idle", 32'(out_valid), 32'd0);
         chk("inflight", 32'(inflight), 32'(q.size()));
         chk("delivered", 32'(delivered), 32'(m_deliv));
      end
   end

   task automatic step(input bit iv, input logic [3:0] id, input bit ce,
                       input bit ce_empty, input logic [3:0] cd);
      bit ok;
      @(negedge clk);
      in_valid = iv; in_data = id;
      chk_en = ce; chk_empty = ce_empty; chk_data = cd;
      if (iv) q.push_back('{d: id, due: cyc + 1 + DELAY});
      ok = ce_empty ? !m_deliv : (m_deliv && m_value == cd);
      if (ce && ok && m_pass != 255) m_pass++;
      if (ce && !ok) m_fail = 1'b1;
      @(posedge clk);
      #1;
      chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 4'h0, 0, 0, 4'h0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; chk_en = 1'b0;
      q.delete();
      m_value = '0; m_deliv = 1'b0; m_pass = 0; m_fail = 1'b0;
      #1;
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_delivered", 32'(delivered), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset(2);
      mon_on = 1'b1;
      // empty check with nothing launched
      idle(1);
      step(0, 4'h0, 1, 1, 4'h0);
      chk("empty_value", 32'(value), 32'd0);
      // single launch, delivered exactly DELAY edges later
      step(1, 4'h1, 0, 0, 4'h0);
      idle(14);
      step(0, 4'h0, 1, 0, 4'h1);
      // burst of three
      step(1, 4'h3, 0, 0, 4'h0);
      step(1, 4'h5, 0, 0, 4'h0);
      step(1, 4'h7, 0, 0, 4'h0);
      chk("burst_inflight", 32'(inflight), 32'd3);
      idle(12);
      chk("burst_value", 32'(value), 32'd7);
      // check on the delivery cycle sees the old value
      step(1, 4'h3, 0, 0, 4'h0);
      idle(12);
      step(1, 4'h9, 0, 0, 4'h0);
      idle(9);
      step(0, 4'h0, 1, 0, 4'h3);
      chk("same_cycle_pass_fail", 32'(fail), 32'd0);
      step(1, 4'h3, 0, 0, 4'h0);
      idle(12);
      step(1, 4'h9, 0, 0, 4'h0);
      idle(9);
      step(0, 4'h0, 1, 0, 4'h9);
      chk("same_cycle_fail", 32'(fail), 32'd1);
      // reset while a value is in flight
      step(1, 4'hA, 0, 0, 4'h0);
      idle(3);
      do_reset(2);
      idle(15);
      chk("post_rst_delivered", 32'(delivered), 32'd0);
      chk("post_rst_value", 32'(value), 32'd0);
      // saturation, then a mismatch
      repeat (260) step(0, 4'h0, 1, 1, 4'h0);
      chk("sat_pass_cnt", 32'(pass_cnt), 32'd255);
      step(0, 4'h0, 1, 0, 4'h0);
      chk("sat_fail", 32'(fail), 32'd1);
      chk("sat_hold", 32'(pass_cnt), 32'd255);
      idle(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
